// File: rtl/slot_pkg.sv
// Shared definitions for the slot machine credit path: win codes, controller
// state encoding and the payout lookup.
package slot_pkg;

  localparam logic [1:0] WIN_NONE    = 2'b00;
  localparam logic [1:0] WIN_SMALL   = 2'b01;
  localparam logic [1:0] WIN_BIG     = 2'b10;
  localparam logic [1:0] WIN_JACKPOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    PAYOUT = 2'd2
  } state_e;

  // Credits awarded for a win code; a lose pays nothing.
  function automatic logic [31:0] pay_lookup(
    input logic [1:0]  code,
    input int unsigned pay_small,
    input int unsigned pay_big,
    input int unsigned pay_jackpot
  );
    logic [31:0] amt;
    case (code)
      WIN_SMALL:   amt = pay_small;
      WIN_BIG:     amt = pay_big;
      WIN_JACKPOT: amt = pay_jackpot;
      default:     amt = 32'd0;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser for a raw active-low pushbutton followed by a
// falling-edge detector; emits one press pulse per physical press.
module button_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic btn_n,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the raw level through the synchroniser and keep the last synced value.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Released-button level (1) after reset so no spurious press is produced.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign press = prev_q & ~sync2_q;

endmodule

// File: rtl/credit_controller.sv
// Credit/bet controller: owns the player's credit, debits a bet per start
// press, requests a spin from the reel block and adds a saturating payout.
module credit_controller
  import slot_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned BET         = 1,
  parameter int unsigned PAY_SMALL   = 2,
  parameter int unsigned PAY_BIG     = 5,
  parameter int unsigned PAY_JACKPOT = 20
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                clear,
  input  logic                load,
  input  logic [CREDIT_W-1:0] credit_in,
  input  logic                start_n,
  input  logic                spin_done,
  input  logic [1:0]          win_code,
  output logic                spin_go,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                reject,
  output logic                sat
);

  localparam int unsigned         SUM_W      = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] BET_C      = CREDIT_W'(BET);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  state_e                state_q,   state_d;
  logic [CREDIT_W-1:0]   credit_q,  credit_d;
  logic                  spin_go_q, spin_go_d;
  logic                  reject_q,  reject_d;
  logic                  sat_q,     sat_d;
  logic [1:0]            win_q,     win_d;

  logic                  press;
  logic [SUM_W-1:0]      pay_amt;
  logic [SUM_W-1:0]      pay_sum;

  // Clip a widened credit sum to the largest representable credit.
  function automatic logic [CREDIT_W-1:0] sat_clip(input logic [SUM_W-1:0] sum);
    return sum[CREDIT_W] ? CREDIT_MAX : sum[CREDIT_W-1:0];
  endfunction

  button_edge_sync u_start_sync (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .btn_n  (start_n),
    .press  (press)
  );

  // The registered win code selects the payout; the sum keeps one carry bit.
  assign pay_amt = SUM_W'(pay_lookup(win_q, PAY_SMALL, PAY_BIG, PAY_JACKPOT));
  assign pay_sum = {1'b0, credit_q} + pay_amt;

  // State register plus all registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      spin_go_q <= 1'b0;
      reject_q  <= 1'b0;
      sat_q     <= 1'b0;
      win_q     <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      spin_go_q <= spin_go_d;
      reject_q  <= reject_d;
      sat_q     <= sat_d;
      win_q     <= win_d;
    end
  end

  // Next state: clear aborts anything, load pins IDLE, otherwise the spin flow.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (load && (state_q == IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (press && (credit_q >= BET_C)) state_d = SPIN;
        SPIN:    if (spin_done) state_d = PAYOUT;
        PAYOUT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of credit, pulses, sticky saturation and captured win code.
  always_comb begin
    credit_d  = credit_q;
    spin_go_d = 1'b0;
    reject_d  = 1'b0;
    sat_d     = sat_q;
    win_d     = win_q;
    if (clear) begin
      credit_d = '0;
      sat_d    = 1'b0;
    end else if (load && (state_q == IDLE)) begin
      // A press edge arriving now is deliberately dropped.
      credit_d = credit_in;
      sat_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            if (credit_q >= BET_C) begin
              credit_d  = credit_q - BET_C;
              spin_go_d = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        SPIN: begin
          if (spin_done) win_d = win_code;
        end
        PAYOUT: begin
          credit_d = sat_clip(pay_sum);
          if (pay_sum[CREDIT_W]) sat_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign spin_go = spin_go_q;
  assign credit  = credit_q;
  assign reject  = reject_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_credit_controller.sv
// Bench for credit_controller: directed scenarios, a rule-level reference
// model compared every cycle, and literal checkpoints.
module tb_credit_controller;

  localparam int CW = 8;
  localparam int BET = 1;
  localparam int CMAX = 255;

  logic          clk;
  logic          resetn;
  logic          clear;
  logic          load;
  logic [CW-1:0] credit_in;
  logic          start_n;
  logic          spin_done;
  logic [1:0]    win_code;
  logic          spin_go;
  logic [CW-1:0] credit;
  logic          busy;
  logic          reject;
  logic          sat;

  int total = 0;
  int bad   = 0;

  credit_controller #(
    .CREDIT_W(CW), .BET(BET), .PAY_SMALL(2), .PAY_BIG(5), .PAY_JACKPOT(20)
  ) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .clear     (clear),
    .load      (load),
    .credit_in (credit_in),
    .start_n   (start_n),
    .spin_done (spin_done),
    .win_code  (win_code),
    .spin_go   (spin_go),
    .credit    (credit),
    .busy      (busy),
    .reject    (reject),
    .sat       (sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sampled button history: b1 = one edge ago, b2 = two, b3 = three.
  int  m_credit;
  bit  m_sat, m_go, m_rej, m_valid;
  int  m_phase;            // 0 waiting for a press, 1 spin outstanding, 2 paying
  int  m_win;
  bit  b1, b2, b3;
  int  pay_tab [4] = '{0, 2, 5, 20};

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    bit pressed;
    int sum;
    if (!resetn) begin
      m_credit = 0; m_sat = 0; m_go = 0; m_rej = 0; m_phase = 0; m_win = 0;
      b1 = 1; b2 = 1; b3 = 1;
      m_valid = 1;
    end else begin
      // A press reaches the controller when the level sampled three edges ago
      // was high and the one two edges ago was low.
      pressed = b3 & ~b2;
      b3 = b2; b2 = b1; b1 = start_n;
      m_go = 0; m_rej = 0;
      if (clear) begin
        m_credit = 0; m_sat = 0; m_phase = 0;
      end else if (load && m_phase == 0) begin
        m_credit = int'(credit_in); m_sat = 0;
      end else if (m_phase == 0) begin
        if (pressed) begin
          if (m_credit >= BET) begin
            m_credit = m_credit - BET; m_go = 1; m_phase = 1;
          end else begin
            m_rej = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (spin_done) begin
          m_win = int'(win_code); m_phase = 2;
        end
      end else begin
        sum = m_credit + pay_tab[m_win];
        if (sum > CMAX) begin
          m_credit = CMAX; m_sat = 1;
        end else begin
          m_credit = sum;
        end
        m_phase = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("credit", 32'(credit), 32'(m_credit));
      chk("sat", 32'(sat), 32'(m_sat));
      chk("spin_go", 32'(spin_go), 32'(m_go));
      chk("reject", 32'(reject), 32'(m_rej));
      chk("busy", 32'(busy), 32'(m_phase != 0));
    end
  end

  // Pulse counters for the literal checkpoints.
  int go_cnt = 0;
  int rej_cnt = 0;
  always @(negedge clk) begin
    if (spin_go === 1'b1) go_cnt++;
    if (reject === 1'b1) rej_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; credit_in = CW'(v);
    tick(1);
    load = 1'b0;
  endtask

  task automatic tap_button();
    start_n = 1'b0;
    tick(1);
    start_n = 1'b1;
  endtask

  task automatic wait_go(input string name);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (spin_go === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: spin_go not seen within 10 cycles, expected a pulse", name);
    end
  endtask

  task automatic pulse_done(input logic [1:0] w);
    spin_done = 1'b1; win_code = w;
    tick(1);
    spin_done = 1'b0; win_code = 2'b00;
  endtask

  int g0, r0;

  initial begin
    resetn = 1'b0; clear = 1'b0; load = 1'b0; credit_in = '0;
    start_n = 1'b1; spin_done = 1'b0; win_code = 2'b00;
    tick(3);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_spin_go", 32'(spin_go), 0);
    resetn = 1'b1;
    tick(2);

    // Lose: 3 -> 2, result returned in the spin_go cycle.
    do_load(3);
    g0 = go_cnt;
    tap_button();
    wait_go("lose_go");
    chk("lose_debit", 32'(credit), 2);
    pulse_done(2'b00);
    chk("lose_busy_payout", 32'(busy), 1);
    tick(1);
    chk("lose_busy_done", 32'(busy), 0);
    tick(2);
    chk("lose_credit", 32'(credit), 2);
    chk("lose_one_go", 32'(go_cnt - g0), 1);

    // Small win: 3 -> 2 -> 4.
    do_load(3);
    tap_button();
    wait_go("small_go");
    chk("small_debit", 32'(credit), 2);
    tick(2);
    pulse_done(2'b01);
    tick(2);
    chk("small_credit", 32'(credit), 4);

    // Big win: 7 -> 6 -> 11.
    do_load(7);
    tap_button();
    wait_go("big_go");
    chk("big_debit", 32'(credit), 6);
    pulse_done(2'b10);
    tick(2);
    chk("big_credit", 32'(credit), 11);
    chk("big_sat", 32'(sat), 0);

    // No credit: reject only.
    clear = 1'b1; tick(1); clear = 1'b0;
    g0 = go_cnt; r0 = rej_cnt;
    tap_button();
    tick(6);
    chk("rej_pulses", 32'(rej_cnt - r0), 1);
    chk("rej_no_go", 32'(go_cnt - g0), 0);
    chk("rej_busy", 32'(busy), 0);
    chk("rej_credit", 32'(credit), 0);

    // Jackpot saturates: 250 -> 249 -> 255, sat sticky until a load.
    do_load(250);
    tap_button();
    wait_go("jack_go");
    chk("jack_debit", 32'(credit), 249);
    pulse_done(2'b11);
    tick(2);
    chk("jack_credit", 32'(credit), 255);
    chk("jack_sat", 32'(sat), 1);
    do_load(10);
    tick(1);
    chk("reload_credit", 32'(credit), 10);
    chk("reload_sat", 32'(sat), 0);

    // Clear during SPIN aborts; a late result is ignored.
    do_load(5);
    tap_button();
    wait_go("clr_go");
    tick(1);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("clr_credit", 32'(credit), 0);
    chk("clr_busy", 32'(busy), 0);
    tick(1);
    pulse_done(2'b10);
    tick(2);
    chk("clr_late_credit", 32'(credit), 0);
    chk("clr_late_busy", 32'(busy), 0);

    // Held button, load and second press during SPIN are all ignored.
    do_load(4);
    g0 = go_cnt;
    start_n = 1'b0;
    wait_go("hold_go");
    tick(5);
    load = 1'b1; credit_in = 8'd9;
    tick(1);
    load = 1'b0;
    tick(92);
    start_n = 1'b1;
    tick(4);
    tap_button();
    tick(6);
    chk("hold_busy", 32'(busy), 1);
    chk("hold_credit", 32'(credit), 3);
    pulse_done(2'b01);
    tick(3);
    chk("hold_final", 32'(credit), 5);
    chk("hold_one_go", 32'(go_cnt - g0), 1);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/credit_controller.md
Name: credit_controller

Overview:
- Parametrised next-generation credit/bet controller for the slot machine; owns the player's credit register.
- Debits a configurable bet on each start press, hands a spin request to the reel block and waits for its result.
- Credits a win-code-dependent payout with saturation.
- Sits between the board I/O (KEY/SW) and the reel/display logic.

Parameters:
- CREDIT_W, 8: credit register width in bits.
- BET, 1: credits debited per spin. Constraint: 1 <= BET < 2^CREDIT_W.
- PAY_SMALL, 2: credits added for win_code 2'b01.
- PAY_BIG, 5: credits added for win_code 2'b10.
- PAY_JACKPOT, 20: credits added for win_code 2'b11.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- clear  in  1  level; zeroes credit and aborts any spin.
- load  in  1  level; loads credit_in while idle.
- credit_in  in  CREDIT_W  value to load.
- start_n  in  1  raw active-low pushbutton (KEY[0]); asynchronous.
- spin_done  in  1  one-cycle pulse from the reel block.
- win_code  in  2  result; valid only with spin_done. 00 lose, 01 small, 10 big, 11 jackpot.
- spin_go  out  1  one-cycle spin request to the reel block.
- credit  out  CREDIT_W  current credit.
- busy  out  1  high in SPIN and PAYOUT.
- reject  out  1  one-cycle pulse: start pressed with credit < BET.
- sat  out  1  sticky: a payout was clipped at the maximum credit.

Behaviour:
- Reset (resetn=0 at a clock edge): credit=0, state=IDLE, spin_go=0, reject=0, sat=0, synchroniser flops=1.
- Control priority, every cycle: resetn > clear > load > FSM.
- clear: credit=0, sat=0, state=IDLE, spin_go=0, reject=0; legal in any state. A spin_done arriving later while IDLE is ignored.
- load: honoured only in IDLE. Sets credit=credit_in and sat=0. Ignored in SPIN/PAYOUT. While load=1 in IDLE, a press edge is discarded.
- start_n passes through a 2-flop synchroniser, then a falling-edge detector.
  - press = prev_sync & ~sync, one cycle per physical press.
  - Holding the button low produces exactly one press.
  - Press-to-FSM latency is 3 cycles from the raw edge.
- IDLE:
  - press with credit >= BET: credit <= credit - BET; spin_go <= 1 for exactly one cycle; go to SPIN.
  - press with credit < BET: reject <= 1 for one cycle; credit unchanged; stay IDLE.
  - Presses arriving in SPIN or PAYOUT are dropped (no queueing, no reject).
- SPIN:
  - Waits indefinitely for spin_done. No timeout.
  - spin_done is accepted in any SPIN cycle, including the cycle spin_go is high.
  - On spin_done, win_code is registered and the state goes to PAYOUT.
- PAYOUT (exactly one cycle):
  - credit <= min(credit + pay(win_code), 2^CREDIT_W - 1).
  - If clipped, sat <= 1.
  - pay(00) = 0.
  - Go to IDLE.
- Arithmetic width: sum computed in CREDIT_W+1 bits, then clipped. The debit never underflows, because the credit >= BET check guards it.
- busy is decoded combinationally from state. All other outputs are registered.
- Cycle timing for a lose: IDLE press at t; spin_go=1 and busy=1 at t+1; spin_done at t+k; PAYOUT at t+k+1; IDLE and busy=0 at t+k+2.

Decomposition:
- Package slot_pkg holds:
  - win-code constants WIN_NONE/WIN_SMALL/WIN_BIG/WIN_JACKPOT;
  - FSM state encoding IDLE/SPIN/PAYOUT (2-bit);
  - the payout lookup function taking the PAY_* parameters.
- One sub-module, button_edge_sync: 2-flop synchroniser plus falling-edge pulse. It is reused later for KEY[1..3].

Test Plan:
- Reset then load 3, press, spin_done with win 00 -> credit 2 one cycle after spin_go, single spin_go pulse, busy low 2 cycles after spin_done, final credit 2.
- Load 3, press, win 01 -> credit 3->2->4; load 7, press, win 10 -> 7->6->11; sat stays 0.
- Credit 0, press -> reject pulse of 1 cycle, no spin_go, busy 0, credit 0.
- Load 250, press, win 11 -> credit 249, then 255 (not 269), sat=1; a following load of 10 -> credit 10, sat=0.
- Load 5, press, assert clear during SPIN -> credit 0, IDLE, busy 0; a spin_done with win 10 two cycles later leaves credit 0.
- Hold start_n low 100 cycles, pulse load=1 with credit_in 9 during SPIN, press again during SPIN -> exactly one spin_go, load ignored, post-spin credit = original - 1 + payout.
